// File: rtl/nco_ctrl_pkg.sv
// Shared types and defaults for the carrier NCO sweep controller.
package nco_ctrl_pkg;

    localparam int WIDTH_DEF   = 64;
    localparam int DWELL_W_DEF = 32;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/nco_sweep_ctrl_if.sv
// Tuning-command handshake between host/config logic and the sweep controller.
interface nco_sweep_ctrl_if
    import nco_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) ();

    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_mode;
    logic [WIDTH-1:0]   cmd_start_inc;
    logic [WIDTH-1:0]   cmd_step_inc;
    logic [WIDTH-1:0]   cmd_stop_inc;
    logic [DWELL_W-1:0] cmd_dwell;

    modport master (
        output cmd_valid, cmd_mode, cmd_start_inc, cmd_step_inc, cmd_stop_inc, cmd_dwell,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_start_inc, cmd_step_inc, cmd_stop_inc, cmd_dwell,
        output cmd_ready
    );

endinterface

// File: rtl/nco_dwell_timer.sv
// Dwell down-counter: holds max(dwell,1)-1 as reload value and flags expiry at zero.
module nco_dwell_timer
    import nco_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               reload_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               expire_o
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] reload_q;
    logic [DWELL_W-1:0] clamped;

    // A dwell of 0 is treated as 1, so both map to an immediate-expiry reload of 0.
    assign clamped  = (load_val_i == '0) ? '0 : (load_val_i - DWELL_W'(1));
    assign expire_o = (count_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            reload_q <= '0;
        end else if (load_i) begin
            count_q  <= clamped;
            reload_q <= clamped;
        end else if (reload_i) begin
            count_q  <= reload_q;
        end else if (count_q != '0) begin
            count_q  <= count_q - DWELL_W'(1);
        end
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Carrier NCO phase-increment sequencer: single retune or linear sweep with per-point dwell.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    nco_sweep_ctrl_if.slave  cmd,
    input  logic             abort_i,
    output logic [WIDTH-1:0] phase_inc_carr_o,
    output logic             inc_update_o,
    output logic             busy_o,
    output logic             sweep_done_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] stop_q, stop_d;
    logic             inc_update_q, inc_update_d;
    logic             tmr_load, tmr_reload, tmr_expire;
    logic [WIDTH:0]   next_sum;
    logic             sweep_end;

    // Carry bit of the extended sum catches wrap-around past 2^WIDTH.
    assign next_sum  = {1'b0, phase_q} + {1'b0, step_q};
    assign sweep_end = next_sum[WIDTH] || (next_sum[WIDTH-1:0] > stop_q) || (step_q == '0);

    nco_dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .reload_i   (tmr_reload),
        .load_val_i (cmd.cmd_dwell),
        .expire_o   (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            step_q       <= '0;
            stop_q       <= '0;
            inc_update_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            step_q       <= step_d;
            stop_q       <= stop_d;
            inc_update_q <= inc_update_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        step_d       = step_q;
        stop_d       = stop_q;
        inc_update_d = 1'b0;
        tmr_load     = 1'b0;
        tmr_reload   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    phase_d      = cmd.cmd_start_inc;
                    inc_update_d = 1'b1;
                    if (cmd.cmd_mode == MODE_SWEEP) begin
                        step_d   = cmd.cmd_step_inc;
                        stop_d   = cmd.cmd_stop_inc;
                        tmr_load = 1'b1;
                        state_d  = ST_DWELL;
                    end
                end
            end
            ST_DWELL: begin
                // Abort wins over both a step and the end-of-sweep transition.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (tmr_expire) begin
                    if (sweep_end) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d      = next_sum[WIDTH-1:0];
                        inc_update_d = 1'b1;
                        tmr_reload   = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd.cmd_ready     = (state_q == ST_IDLE) && !rst;
    assign phase_inc_carr_o  = phase_q;
    assign inc_update_o      = inc_update_q;
    assign busy_o            = (state_q == ST_DWELL);
    assign sweep_done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Directed self-checking bench for nco_sweep_ctrl: fixed, sweep, edge cases, abort, ignore, reset.
module tb_nco_sweep_ctrl;
    import nco_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        abort;
    logic [63:0] phase;
    logic        inc_update;
    logic        busy;
    logic        sweep_done;

    int vectors;
    int miscompares;

    nco_sweep_ctrl_if #(.WIDTH(64), .DWELL_W(32)) cmd_if ();

    nco_sweep_ctrl #(
        .WIDTH   (64),
        .DWELL_W (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cmd              (cmd_if),
        .abort_i          (abort),
        .phase_inc_carr_o (phase),
        .inc_update_o     (inc_update),
        .busy_o           (busy),
        .sweep_done_o     (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends even if something stalls.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one command for exactly one edge; returns 1ns after the accepting edge.
    task automatic send_cmd(input logic mode, input logic [63:0] start, input logic [63:0] step,
                            input logic [63:0] stop, input logic [31:0] dwell);
        cmd_if.cmd_mode      = mode;
        cmd_if.cmd_start_inc = start;
        cmd_if.cmd_step_inc  = step;
        cmd_if.cmd_stop_inc  = stop;
        cmd_if.cmd_dwell     = dwell;
        cmd_if.cmd_valid     = 1'b1;
        tick();
        cmd_if.cmd_valid     = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        vectors++; if (phase !== 64'd0) begin miscompares++; $display("[TB] FAIL reset_phase: got %h expected %h", phase, 64'd0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (inc_update !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_inc_update: got %b expected 0", inc_update); end
        vectors++; if (sweep_done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sweep_done: got %b expected 0", sweep_done); end
        vectors++; if (cmd_if.cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready_in_rst: got %b expected 0", cmd_if.cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++; if (cmd_if.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready_after: got %b expected 1", cmd_if.cmd_ready); end
        tick();
    endtask

    task automatic test_fixed();
        send_cmd(MODE_FIXED, 64'h0000_1000_0000_0000, 64'd0, 64'd0, 32'd0);
        vectors++; if (phase !== 64'h0000_1000_0000_0000) begin miscompares++; $display("[TB] FAIL fixed_phase: got %h expected %h", phase, 64'h0000_1000_0000_0000); end
        vectors++; if (inc_update !== 1'b1) begin miscompares++; $display("[TB] FAIL fixed_inc_pulse: got %b expected 1", inc_update); end
        vectors++; if (cmd_if.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fixed_ready: got %b expected 1", cmd_if.cmd_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL fixed_busy: got %b expected 0", busy); end
        tick();
        vectors++; if (inc_update !== 1'b0) begin miscompares++; $display("[TB] FAIL fixed_inc_single: got %b expected 0", inc_update); end
        vectors++; if (phase !== 64'h0000_1000_0000_0000) begin miscompares++; $display("[TB] FAIL fixed_hold: got %h expected %h", phase, 64'h0000_1000_0000_0000); end
    endtask

    task automatic test_back_to_back();
        cmd_if.cmd_mode      = MODE_FIXED;
        cmd_if.cmd_start_inc = 64'h1111;
        cmd_if.cmd_valid     = 1'b1;
        tick();
        vectors++; if (phase !== 64'h1111) begin miscompares++; $display("[TB] FAIL b2b_first: got %h expected %h", phase, 64'h1111); end
        cmd_if.cmd_start_inc = 64'h2222;
        tick();
        cmd_if.cmd_valid     = 1'b0;
        vectors++; if (phase !== 64'h2222) begin miscompares++; $display("[TB] FAIL b2b_second: got %h expected %h", phase, 64'h2222); end
        vectors++; if (inc_update !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_inc: got %b expected 1", inc_update); end
        tick();
        vectors++; if (inc_update !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_inc_end: got %b expected 0", inc_update); end
    endtask

    // npts and the per-point dwell are worked out by hand for each call.
    task automatic test_sweep(input string name, input logic [63:0] start, input logic [63:0] step,
                              input logic [63:0] stop, input logic [31:0] dwell, input int npts);
        int          d;
        int          span;
        int          pulses;
        logic [63:0] exp_phase;
        logic        exp_inc, exp_busy, exp_done, exp_ready;
        d      = (dwell == 32'd0) ? 1 : int'(dwell);
        span   = npts * d;
        pulses = 0;
        send_cmd(MODE_SWEEP, start, step, stop, dwell);
        for (int t = 0; t <= span + 1; t++) begin
            exp_phase = (t < span) ? start + step * 64'(t / d) : start + step * 64'(npts - 1);
            exp_inc   = (t < span) && ((t % d) == 0);
            exp_busy  = (t < span);
            exp_done  = (t == span);
            exp_ready = (t > span);
            vectors++; if (phase !== exp_phase) begin miscompares++; $display("[TB] FAIL %s phase t=%0d: got %h expected %h", name, t, phase, exp_phase); end
            vectors++; if (inc_update !== exp_inc) begin miscompares++; $display("[TB] FAIL %s inc_update t=%0d: got %b expected %b", name, t, inc_update, exp_inc); end
            vectors++; if (busy !== exp_busy) begin miscompares++; $display("[TB] FAIL %s busy t=%0d: got %b expected %b", name, t, busy, exp_busy); end
            vectors++; if (sweep_done !== exp_done) begin miscompares++; $display("[TB] FAIL %s sweep_done t=%0d: got %b expected %b", name, t, sweep_done, exp_done); end
            vectors++; if (cmd_if.cmd_ready !== exp_ready) begin miscompares++; $display("[TB] FAIL %s ready t=%0d: got %b expected %b", name, t, cmd_if.cmd_ready, exp_ready); end
            if (inc_update) pulses++;
            tick();
        end
        vectors++; if (pulses != npts) begin miscompares++; $display("[TB] FAIL %s pulse_count: got %0d expected %0d", name, pulses, npts); end
    endtask

    task automatic test_abort();
        send_cmd(MODE_SWEEP, 64'd0, 64'd1, 64'd1000, 32'd4);
        for (int t = 0; t < 8; t++) tick();
        abort = 1'b1;
        vectors++; if (phase !== 64'd2) begin miscompares++; $display("[TB] FAIL abort_pre: got %h expected %h", phase, 64'd2); end
        tick();
        abort = 1'b0;
        vectors++; if (phase !== 64'd2) begin miscompares++; $display("[TB] FAIL abort_hold: got %h expected %h", phase, 64'd2); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        vectors++; if (cmd_if.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_ready: got %b expected 1", cmd_if.cmd_ready); end
        for (int t = 0; t < 6; t++) begin
            vectors++; if (sweep_done !== 1'b0 || inc_update !== 1'b0 || phase !== 64'd2) begin
                miscompares++; $display("[TB] FAIL abort_quiet t=%0d: got done=%b inc=%b phase=%h expected 0 0 %h", t, sweep_done, inc_update, phase, 64'd2);
            end
            tick();
        end
        // Abort landing on the same edge as a step must win.
        send_cmd(MODE_SWEEP, 64'd100, 64'd50, 64'd250, 32'd3);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vectors++; if (phase !== 64'd100) begin miscompares++; $display("[TB] FAIL abort_prio_phase: got %h expected %h", phase, 64'd100); end
        vectors++; if (inc_update !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_prio_inc: got %b expected 0", inc_update); end
        vectors++; if (cmd_if.cmd_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL abort_prio_ready: got %b expected 1", cmd_if.cmd_ready); end
        tick();
        vectors++; if (sweep_done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_prio_done: got %b expected 0", sweep_done); end
    endtask

    task automatic test_busy_ignore();
        logic seen_bad;
        seen_bad = 1'b0;
        send_cmd(MODE_SWEEP, 64'd100, 64'd50, 64'd250, 32'd3);
        cmd_if.cmd_mode      = MODE_FIXED;
        cmd_if.cmd_start_inc = 64'hDEAD;
        cmd_if.cmd_valid     = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (phase === 64'hDEAD) seen_bad = 1'b1;
            if (t == 3) begin
                vectors++; if (phase !== 64'd150) begin miscompares++; $display("[TB] FAIL ignore_mid: got %h expected %h", phase, 64'd150); end
            end
            tick();
        end
        cmd_if.cmd_valid = 1'b0;
        for (int t = 6; t < 12; t++) begin
            if (phase === 64'hDEAD) seen_bad = 1'b1;
            tick();
        end
        vectors++; if (sweep_done !== 1'b1) begin miscompares++; $display("[TB] FAIL ignore_done: got %b expected 1", sweep_done); end
        vectors++; if (phase !== 64'd250) begin miscompares++; $display("[TB] FAIL ignore_final: got %h expected %h", phase, 64'd250); end
        vectors++; if (seen_bad !== 1'b0) begin miscompares++; $display("[TB] FAIL ignore_leak: got %b expected 0", seen_bad); end
        tick();
    endtask

    task automatic test_reset_mid();
        send_cmd(MODE_SWEEP, 64'd0, 64'd1, 64'd1000, 32'd4);
        for (int t = 0; t < 5; t++) tick();
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (phase !== 64'd0) begin miscompares++; $display("[TB] FAIL rstmid_phase: got %h expected %h", phase, 64'd0); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
        vectors++; if (cmd_if.cmd_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_ready: got %b expected 0", cmd_if.cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        vectors++; if (phase !== 64'd0) begin miscompares++; $display("[TB] FAIL rstmid_after: got %h expected %h", phase, 64'd0); end
        send_cmd(MODE_FIXED, 64'h1234, 64'd0, 64'd0, 32'd0);
        vectors++; if (phase !== 64'h1234) begin miscompares++; $display("[TB] FAIL rstmid_fixed: got %h expected %h", phase, 64'h1234); end
        vectors++; if (inc_update !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_inc: got %b expected 1", inc_update); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_busy_after: got %b expected 0", busy); end
    endtask

    initial begin
        vectors              = 0;
        miscompares          = 0;
        rst                  = 1'b1;
        abort                = 1'b0;
        cmd_if.cmd_valid     = 1'b0;
        cmd_if.cmd_mode      = MODE_FIXED;
        cmd_if.cmd_start_inc = '0;
        cmd_if.cmd_step_inc  = '0;
        cmd_if.cmd_stop_inc  = '0;
        cmd_if.cmd_dwell     = '0;

        test_reset();
        test_fixed();
        test_back_to_back();
        test_sweep("sweep_basic", 64'd100, 64'd50, 64'd250, 32'd3, 4);
        test_sweep("sweep_overflow", 64'hFFFF_FFFF_FFFF_FFF6, 64'd8, 64'hFFFF_FFFF_FFFF_FFFF, 32'd1, 2);
        test_sweep("sweep_step0", 64'd500, 64'd0, 64'd1000, 32'd2, 1);
        test_sweep("sweep_dwell0", 64'd10, 64'd5, 64'd20, 32'd0, 3);
        test_sweep("sweep_start_gt_stop", 64'd300, 64'd10, 64'd200, 32'd2, 1);
        test_abort();
        test_busy_ignore();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
